// File: rtl/temp_conv_pkg.sv
// Shared constants, output beat type and the shift/round/saturate helper
// for the averaging temperature converter.
package temp_conv_pkg;

    localparam int SENSOR_LSB_FRAC = 4;
    localparam int SENSOR_W        = 12;

    // Beat fields are sized for the largest supported configuration.
    localparam int MAX_CH_W  = 4;
    localparam int MAX_OUT_W = 16;

    typedef struct packed {
        logic [MAX_CH_W-1:0]         ch;
        logic signed [MAX_OUT_W-1:0] temp;
        logic                        sat;
    } out_beat_t;

    typedef struct packed {
        logic signed [31:0] val;
        logic               sat;
    } round_sat_t;

    // The 32-bit working width covers sums of up to 30 bits, so adding the
    // rounding half can never overflow.
    function automatic round_sat_t sat_round(
        input logic signed [31:0] sum,
        input int                 sh,
        input logic               rnd,
        input int                 out_w
    );
        logic signed [31:0] w;
        logic signed [31:0] q;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        round_sat_t         r;
        w = sum;
        if (rnd && sh > 0) begin
            w = w + (32'sd1 <<< (sh - 1));
        end
        q  = w >>> sh;
        hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (out_w - 1));
        r.sat = (q > hi) || (q < lo);
        if (q > hi) begin
            r.val = hi;
        end else if (q < lo) begin
            r.val = lo;
        end else begin
            r.val = q;
        end
        return r;
    endfunction

endpackage

// File: rtl/temp_round_sat.sv
// Combinational conversion of an accumulated fixed-point sum into a
// saturated signed integer degree value (round half up or floor).
module temp_round_sat
    import temp_conv_pkg::*;
#(
    parameter int SUM_W = 14,
    parameter int SH    = 6,
    parameter int OUT_W = 8
) (
    input  logic signed [SUM_W-1:0] i_sum,
    input  logic                    i_round,
    output logic signed [OUT_W-1:0] o_temp,
    output logic                    o_sat
);

    round_sat_t w_res;

    assign w_res  = sat_round(32'(i_sum), SH, i_round, OUT_W);
    assign o_temp = w_res.val[OUT_W-1:0];
    assign o_sat  = w_res.sat;

endmodule

// File: rtl/temperature_converter_avg.sv
// Multi-channel sensor averager: accumulates 2^AVG_LOG2 tagged samples per
// channel and emits one saturated integer degree result per completed set.
module temperature_converter_avg
    import temp_conv_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int IN_W      = SENSOR_W,
    parameter int FRAC_BITS = SENSOR_LSB_FRAC,
    parameter int OUT_W     = 8,
    parameter int AVG_LOG2  = 2,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    cfg_round,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CH_W-1:0]         in_ch,
    input  logic signed [IN_W-1:0]  in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CH_W-1:0]         out_ch,
    output logic signed [OUT_W-1:0] out_temp,
    output logic                    out_sat
);

    localparam int ACC_W = IN_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int SH    = FRAC_BITS + AVG_LOG2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic signed [ACC_W-1:0] r_acc [NUM_CH];
    logic [CNT_W-1:0]        r_cnt [NUM_CH];

    logic                    r_out_valid;
    logic [CH_W-1:0]         r_out_ch;
    logic signed [OUT_W-1:0] r_out_temp;
    logic                    r_out_sat;

    logic                    w_accept;
    logic                    w_ch_ok;
    logic                    w_last;
    logic                    w_complete;
    logic signed [ACC_W-1:0] w_acc_cur;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [OUT_W-1:0] w_temp;
    logic                    w_sat;

    // Both streams transfer on a rising edge where valid && ready. The
    // output is a single held register, so a new sample is taken only when
    // that register is empty or being drained in the same cycle.
    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready && !clr;
    assign w_ch_ok    = {1'b0, in_ch} < (CH_W + 1)'(NUM_CH);
    assign w_acc_cur  = w_ch_ok ? r_acc[in_ch] : '0;
    assign w_last     = w_ch_ok ? (r_cnt[in_ch] == CNT_LAST) : 1'b0;
    assign w_sum      = w_acc_cur + ACC_W'(in_data);
    assign w_complete = w_accept && w_ch_ok && w_last;

    temp_round_sat #(
        .SUM_W (ACC_W),
        .SH    (SH),
        .OUT_W (OUT_W)
    ) u_round_sat (
        .i_sum   (w_sum),
        .i_round (cfg_round),
        .o_temp  (w_temp),
        .o_sat   (w_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i] <= '0;
                r_cnt[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i] <= '0;
                r_cnt[i] <= '0;
            end
        end else if (w_accept && w_ch_ok) begin
            // The completing sample restarts the set; its sum goes straight to rounding.
            if (w_last) begin
                r_acc[in_ch] <= '0;
                r_cnt[in_ch] <= '0;
            end else begin
                r_acc[in_ch] <= w_sum;
                r_cnt[in_ch] <= r_cnt[in_ch] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_temp  <= '0;
            r_out_sat   <= 1'b0;
        end else if (clr) begin
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_temp  <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_complete) begin
            r_out_valid <= 1'b1;
            r_out_ch    <= in_ch;
            r_out_temp  <= w_temp;
            r_out_sat   <= w_sat;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;
    assign out_temp  = r_out_temp;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_temperature_converter_avg.sv
// Scoreboard bench: one instance without averaging, one averaging 4 samples
// over 3 channels; expected beats are queued at issue and popped by monitors.
module tb_temperature_converter_avg;
    import temp_conv_pkg::*;

    localparam int BEAT_W = $bits(out_beat_t);

    logic clk;
    logic rst_n;

    logic              clr0, round0, in_valid0, in_ready0, out_valid0, out_ready0, out_sat0;
    logic [1:0]        in_ch0, out_ch0;
    logic signed [11:0] in_data0;
    logic signed [7:0] out_temp0;

    logic              clr2, round2, in_valid2, in_ready2, out_valid2, out_ready2, out_sat2;
    logic [1:0]        in_ch2, out_ch2;
    logic signed [11:0] in_data2;
    logic signed [7:0] out_temp2;

    logic [BEAT_W-1:0] exp_q0[$];
    logic [BEAT_W-1:0] exp_q2[$];

    int cmp_cnt  = 0;
    int fail_cnt = 0;

    temperature_converter_avg #(.NUM_CH(4), .AVG_LOG2(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr0), .cfg_round(round0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_ch(in_ch0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_ch(out_ch0),
        .out_temp(out_temp0), .out_sat(out_sat0)
    );

    temperature_converter_avg #(.NUM_CH(3), .AVG_LOG2(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .clr(clr2), .cfg_round(round2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_ch(in_ch2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_ch(out_ch2),
        .out_temp(out_temp2), .out_sat(out_sat2)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [BEAT_W-1:0] beat(input int ch, input int temp, input logic sat);
        out_beat_t b;
        b.ch   = MAX_CH_W'(ch);
        b.temp = MAX_OUT_W'(temp);
        b.sat  = sat;
        return b;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        cmp_cnt++;
        if (act != exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int d, input int ch, input int temp, input logic sat);
        if (d == 0) exp_q0.push_back(beat(ch, temp, sat));
        else        exp_q2.push_back(beat(ch, temp, sat));
    endtask

    // Called in the low clock phase; returns at the negedge after acceptance.
    task automatic send(input int d, input int ch, input logic [11:0] data, input logic rnd);
        int budget;
        budget = 0;
        #1;
        while (!(d == 0 ? in_ready0 : in_ready2)) begin
            budget++;
            if (budget > 50) begin
                cmp_cnt++;
                fail_cnt++;
                $display("FAIL send_timeout: dut%0d in_ready stayed 0 for %0d cycles", d, budget);
                return;
            end
            @(negedge clk);
            #1;
        end
        if (d == 0) begin
            in_valid0 = 1'b1; in_ch0 = 2'(ch); in_data0 = data; round0 = rnd;
        end else begin
            in_valid2 = 1'b1; in_ch2 = 2'(ch); in_data2 = data; round2 = rnd;
        end
        @(negedge clk);
        if (d == 0) in_valid0 = 1'b0;
        else        in_valid2 = 1'b0;
    endtask

    // ---------------- monitors ----------------
    always begin
        @(negedge clk);
        #1;
        if (rst_n && out_valid0 && out_ready0) begin
            cmp_cnt++;
            if (exp_q0.size() == 0) begin
                fail_cnt++;
                $display("FAIL dut0_unexpected: got ch=%0d temp=%0d sat=%0d with nothing expected",
                         out_ch0, out_temp0, out_sat0);
            end else begin
                logic [BEAT_W-1:0] e;
                logic [BEAT_W-1:0] a;
                e = exp_q0.pop_front();
                a = beat(int'(out_ch0), int'(out_temp0), out_sat0);
                if (a !== e) begin
                    fail_cnt++;
                    $display("FAIL dut0_beat: got ch=%0d temp=%0d sat=%0d expected beat %h (actual %h)",
                             out_ch0, out_temp0, out_sat0, e, a);
                end
            end
        end
    end

    always begin
        @(negedge clk);
        #1;
        if (rst_n && out_valid2 && out_ready2) begin
            cmp_cnt++;
            if (exp_q2.size() == 0) begin
                fail_cnt++;
                $display("FAIL dut2_unexpected: got ch=%0d temp=%0d sat=%0d with nothing expected",
                         out_ch2, out_temp2, out_sat2);
            end else begin
                logic [BEAT_W-1:0] e;
                logic [BEAT_W-1:0] a;
                e = exp_q2.pop_front();
                a = beat(int'(out_ch2), int'(out_temp2), out_sat2);
                if (a !== e) begin
                    fail_cnt++;
                    $display("FAIL dut2_beat: got ch=%0d temp=%0d sat=%0d expected beat %h (actual %h)",
                             out_ch2, out_temp2, out_sat2, e, a);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        cmp_cnt++;
        fail_cnt++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("End of test - %0d assertions evaluated, %0d failures", cmp_cnt, fail_cnt);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        clr0 = 0; round0 = 0; in_valid0 = 0; in_ch0 = 0; in_data0 = 0; out_ready0 = 1;
        clr2 = 0; round2 = 0; in_valid2 = 0; in_ch2 = 0; in_data2 = 0; out_ready2 = 1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready0", in_ready0, 1);
        check("rst_out_valid0", out_valid0, 0);
        check("rst_out_ch0", out_ch0, 0);
        check("rst_out_temp0", out_temp0, 0);
        check("rst_out_sat0", out_sat0, 0);
        check("rst_in_ready2", in_ready2, 1);
        check("rst_out_valid2", out_valid2, 0);
        @(negedge clk);

        // No averaging: basic conversions, rounding and saturation
        push(0, 0, 25, 0);   send(0, 0, 12'h190, 1);
        #1 check("latency_valid0", out_valid0, 1);
        @(negedge clk);
        push(0, 0, -25, 0);  send(0, 0, 12'hE70, 1);
        push(0, 0, 1, 0);    send(0, 0, 12'h008, 1);
        push(0, 0, 0, 0);    send(0, 0, 12'h008, 0);
        push(0, 0, 0, 0);    send(0, 0, 12'hFF8, 1);
        push(0, 0, -1, 0);   send(0, 0, 12'hFF8, 0);
        push(0, 0, 127, 1);  send(0, 0, 12'h7FF, 1);
        push(0, 0, 127, 0);  send(0, 0, 12'h7FF, 0);
        push(0, 0, -128, 0); send(0, 0, 12'h800, 1);

        // Back-to-back samples on different channels
        push(0, 3, 25, 0);   send(0, 3, 12'h190, 0);
        push(0, 1, 50, 0);   send(0, 1, 12'h320, 1);
        push(0, 2, -50, 0);  send(0, 2, 12'hCE0, 1);
        @(negedge clk);

        // Backpressure: result held, input blocked
        out_ready0 = 1'b0;
        push(0, 1, 25, 0);   send(0, 1, 12'h190, 1);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_out_valid", out_valid0, 1);
            check("bp_in_ready", in_ready0, 0);
            check("bp_out_temp", out_temp0, 25);
            check("bp_out_ch", out_ch0, 1);
            @(negedge clk);
        end
        out_ready0 = 1'b1;
        #1 check("bp_release_in_ready", in_ready0, 1);
        @(negedge clk);
        #1 check("bp_drained_valid", out_valid0, 0);
        @(negedge clk);

        // Averaging with interleaved channels 1 and 2
        send(2, 1, 12'd400, 1); #1 check("avg_no_out_1", out_valid2, 0);
        send(2, 2, 12'd160, 1); #1 check("avg_no_out_2", out_valid2, 0);
        send(2, 1, 12'd400, 1); #1 check("avg_no_out_3", out_valid2, 0);
        send(2, 2, 12'd160, 1); #1 check("avg_no_out_4", out_valid2, 0);
        send(2, 1, 12'd416, 0); #1 check("avg_no_out_5", out_valid2, 0);
        send(2, 2, 12'd160, 1); #1 check("avg_no_out_6", out_valid2, 0);
        push(2, 1, 26, 0);  send(2, 1, 12'd416, 1);
        #1 check("avg_latency_valid", out_valid2, 1);
        push(2, 2, 10, 0);  send(2, 2, 12'd160, 1);

        // Floor on the completing sample after round earlier in the set
        send(2, 1, 12'd400, 1); send(2, 1, 12'd400, 1); send(2, 1, 12'd416, 1);
        push(2, 1, 25, 0);  send(2, 1, 12'd416, 0);

        // Negative average, then saturation through averaging
        for (int i = 0; i < 3; i++) send(2, 0, 12'hE70, 1);
        push(2, 0, -25, 0); send(2, 0, 12'hE70, 1);
        for (int i = 0; i < 3; i++) send(2, 0, 12'h7FF, 1);
        push(2, 0, 127, 1); send(2, 0, 12'h7FF, 1);

        // Channel tag beyond NUM_CH is swallowed
        for (int i = 0; i < 4; i++) begin
            send(2, 3, 12'h190, 1);
            #1 check("bad_ch_no_out", out_valid2, 0);
        end

        // clr after a partial set
        send(2, 0, 12'd400, 1); send(2, 0, 12'd400, 1);
        clr2 = 1'b1;
        @(negedge clk);
        clr2 = 1'b0;
        for (int i = 0; i < 3; i++) send(2, 0, 12'd160, 0);
        push(2, 0, 10, 0);  send(2, 0, 12'd160, 0);

        // clr together with a presented sample
        send(2, 0, 12'd400, 1); send(2, 0, 12'd400, 1);
        clr2 = 1'b1; in_valid2 = 1'b1; in_ch2 = 2'd0; in_data2 = 12'd400;
        @(negedge clk);
        clr2 = 1'b0; in_valid2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(2, 0, 12'd160, 1);
            #1 check("clr_valid_no_out", out_valid2, 0);
        end
        push(2, 0, 10, 0);  send(2, 0, 12'd160, 1);
        @(negedge clk);

        // Async reset with a pending result and a partial set
        out_ready0 = 1'b0;
        send(0, 2, 12'h7FF, 1);
        send(2, 0, 12'd400, 1); send(2, 0, 12'd400, 1);
        #1 check("pre_rst_valid0", out_valid0, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid0", out_valid0, 0);
        check("async_rst_ch0", out_ch0, 0);
        check("async_rst_temp0", out_temp0, 0);
        check("async_rst_sat0", out_sat0, 0);
        check("async_rst_in_ready0", in_ready0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready0 = 1'b1;
        for (int i = 0; i < 3; i++) send(2, 0, 12'd160, 1);
        push(2, 0, 10, 0);  send(2, 0, 12'd160, 1);

        repeat (4) @(negedge clk);
        #1;
        check("dut0_queue_empty", exp_q0.size(), 0);
        check("dut2_queue_empty", exp_q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/temperature_converter_avg.md
Name: temperature_converter_avg

Overview:
Multi-channel successor of the single-sensor temperature converter for P3T1035xUK/P3T2030xUK readings. Each reading is 12-bit two's complement at 0.0625 °C/LSB. The block accepts tagged samples over a valid/ready stream and accumulates 2^AVG_LOG2 samples per channel. It then emits one rounded or floored, saturated signed integer °C result per channel on a valid/ready output stream. It sits between the sensor-readout interface and the control/threshold logic.

Parameters:
NUM_CH, 4, number of sensor channels (1..16)
IN_W, 12, sensor sample width, two's complement
FRAC_BITS, 4, fractional bits of a sample (0.0625 °C/LSB)
OUT_W, 8, signed output temperature width
AVG_LOG2, 2, log2 of samples averaged per result (0 = no averaging)
CH_W, $clog2(NUM_CH) min 1, channel index width (derived, do not override)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear of all accumulators, counters and the output register
cfg_round  input  1  1 = round half up, 0 = floor; sampled on each completing sample
in_valid  input  1  sample valid
in_ready  output  1  block can accept a sample this cycle
in_ch  input  CH_W  channel tag of sample
in_data  input  IN_W  raw signed sensor sample
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_ch  output  CH_W  channel of result
out_temp  output  OUT_W  signed integer °C
out_sat  output  1  result was clipped to the OUT_W range

Behaviour:
- Reset (rst_n low, async): all per-channel accumulators = 0, all counters = 0, out_valid = 0, out_ch = 0, out_temp = 0, out_sat = 0. in_ready = 1 after reset.
- Handshake and flow control:
  - in_ready = !out_valid || out_ready (combinational). A sample is accepted when in_valid && in_ready.
  - Output is a held register: out_ch/out_temp/out_sat stay stable while out_valid && !out_ready. out_valid clears on out_ready unless a new result loads in the same cycle.
- Per-channel state: acc[ch], signed, width IN_W+AVG_LOG2, sign-extended accumulation (no overflow by construction). cnt[ch], width max(AVG_LOG2,1).
- Accepted sample, not the 2^AVG_LOG2-th: acc[ch] += sext(in_data); cnt[ch]++.
- Accepted sample that completes the set (cnt[ch] == 2^AVG_LOG2-1, or always when AVG_LOG2 = 0):
  - sum = acc[ch] + sext(in_data), computed the same cycle.
  - SH = FRAC_BITS + AVG_LOG2.
  - Round mode: q = (sum + 2^(SH-1)) >>> SH. Floor mode: q = sum >>> SH. Both use arithmetic shift; widen the sum by 1 bit before adding so nothing overflows.
  - If q > 2^(OUT_W-1)-1, output max and out_sat = 1. If q < -2^(OUT_W-1), output min and out_sat = 1. Otherwise out_temp = q, out_sat = 0.
  - Registered into the output the next edge: out_valid = 1, out_ch = in_ch. acc[ch] = 0, cnt[ch] = 0.
- Latency: 1 clock from the acceptance of the completing sample to out_valid. Throughput: one sample per clock when out_ready is held high.
- in_ch >= NUM_CH: sample accepted and discarded, no state change, no output.
- Channels are independent; interleaved tags accumulate separately.
- clr has priority over everything except reset. On clr: all acc/cnt = 0, out_valid = 0, and a sample presented in the same cycle is discarded. in_ready is unchanged by clr.
- cfg_round is only relevant in the completion cycle; changing it mid-set is legal.
- Reset asserted mid-accumulation discards partial sets. No output is produced for a partial set.

Decomposition:
- Package temp_conv_pkg:
  - localparams SENSOR_LSB_FRAC = 4 and SENSOR_W = 12.
  - function sat_round(sum, sh, round, out_w) returning the value and sat flag.
  - typedef struct for the output beat {ch, temp, sat}.
- One sub-module, temp_round_sat: combinational shift, round and saturate, parametrised by input width, SH and OUT_W. The top holds the channel state arrays, completion detect and the output register.

Test Plan:
- AVG_LOG2=0, cfg_round=1, in_data 0x190 (25.0 °C), ch 0 -> next cycle out_valid=1, out_temp=25, out_sat=0. Then 0xE70 -> -25.
- AVG_LOG2=0, in_data 0x008 (+0.5) -> round 1, floor 0. in_data 0xFF8 (-0.5) -> round 0, floor -1.
- AVG_LOG2=0, cfg_round=1, in_data 0x7FF (127.9375) -> out_temp=127, out_sat=1. in_data 0x800 (-128.0) -> out_temp=-128, out_sat=0.
- AVG_LOG2=2, ch 1 samples 400, 400, 416, 416 (sum 1632):
  - No output after the first three samples.
  - After the fourth: round out_temp=26, floor 25, out_ch=1.
  - Channel 2 samples interleaved between them produce no cross-talk.
- Backpressure: hold out_ready=0 with a result pending -> in_ready=0 and output fields stable for 5 cycles. Raise out_ready -> one transfer, in_ready=1 the same cycle.
- Pulse clr after 2 of 4 samples on ch 0 (also once with in_valid high) -> the next 4 samples produce exactly one result equal to their own average. Async rst_n mid-set -> all outputs 0 immediately.
